// File: rtl/alu_pkg.sv
// Shared constants for the datapath ALU: widths, opcodes and flag bit positions.
package alu_pkg;

  localparam int DATA_W     = 32;
  localparam int FLAG_WIDTH = 7;

  localparam logic [3:0] ALU_UND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_MOV = 4'b0101;
  localparam logic [3:0] ALU_SLW = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_OR  = 4'b1000;
  localparam logic [3:0] ALU_SHL = 4'b1001;
  localparam logic [3:0] ALU_SHR = 4'b1010;
  localparam logic [3:0] ALU_CMP = 4'b1011;
  localparam logic [3:0] ALU_NOT = 4'b1100;
  localparam logic [3:0] ALU_JMP = 4'b1101;
  localparam logic [3:0] ALU_BFJ = 4'b1110;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam int FLAG_OVF   = 6;
  localparam int FLAG_ABOVE = 5;
  localparam int FLAG_EQ    = 4;
  localparam int FLAG_BELOW = 3;
  localparam int FLAG_ERR   = 0;

endpackage

// File: rtl/alu_flag_match.sv
// Branch-on-flags condition: true when every masked stored flag equals its expected value.
module alu_flag_match
  import alu_pkg::*;
#(
  parameter int FLAG_W = FLAG_WIDTH
) (
  input  logic [FLAG_W-1:0] mask,
  input  logic [FLAG_W-1:0] expected,
  input  logic [FLAG_W-1:0] stored,
  output logic              match
);

  // An unmasked bit always agrees, so an all-zero mask yields a match.
  assign match = &(~mask | ~(stored ^ expected));

endmodule

// File: rtl/alu_unit.sv
// 32-bit integer ALU: one combinational opcode decode feeding a single output register.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int FLAG_W = FLAG_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        Operation,
  input  logic [WIDTH-1:0]  data1,
  input  logic [WIDTH-1:0]  data2,
  input  logic [FLAG_W-1:0] RFlagsStored,
  output logic [WIDTH-1:0]  Result,
  output logic [FLAG_W-1:0] RFlagsOut,
  output logic              Zero
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]          sum;
  logic [WIDTH-1:0]          diff;
  logic                      add_ovf;
  logic                      sub_ovf;
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod;
  logic                      mul_ovf;
  logic                      div_by_zero;
  logic                      div_ovf;
  logic [WIDTH-1:0]          div_den;
  logic signed [WIDTH-1:0]   quot;
  logic                      big_shift;
  logic [WIDTH-1:0]          shl_val;
  logic signed [WIDTH-1:0]   shr_raw;
  logic [WIDTH-1:0]          shr_val;
  logic                      lt;
  logic                      gt;
  logic                      bfj_match;

  logic [WIDTH-1:0]  res_d;
  logic [FLAG_W-1:0] flags_d;
  logic              zero_d;

  assign sum     = data1 + data2;
  assign diff    = data1 - data2;
  assign add_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1]  != data1[WIDTH-1]);
  assign sub_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);

  assign a_ext   = {{WIDTH{data1[WIDTH-1]}}, data1};
  assign b_ext   = {{WIDTH{data2[WIDTH-1]}}, data2};
  assign prod    = a_ext * b_ext;
  // The product fits a signed word only if the upper half is a copy of bit WIDTH-1.
  assign mul_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || (~|prod[2*WIDTH-1:WIDTH-1]));

  // The divider never sees a zero or MIN/-1 divisor; those cases are handled in the decode.
  assign div_by_zero = (data2 == '0);
  assign div_ovf     = (data1 == MIN_NEG) && (&data2);
  assign div_den     = (div_by_zero || div_ovf) ? ONE : data2;
  assign quot        = $signed(data1) / $signed(div_den);

  // Shift amount is the full unsigned data1; anything >= WIDTH saturates.
  assign big_shift = |data1[WIDTH-1:SHAMT_W];
  assign shl_val   = big_shift ? '0 : (data2 << data1[SHAMT_W-1:0]);
  assign shr_raw   = $signed(data2) >>> data1[SHAMT_W-1:0];
  assign shr_val   = big_shift ? {WIDTH{data2[WIDTH-1]}} : shr_raw;

  assign lt = $signed(data1) < $signed(data2);
  assign gt = $signed(data1) > $signed(data2);

  alu_flag_match #(.FLAG_W(FLAG_W)) u_flag_match (
    .mask     (data2[FLAG_W-1:0]),
    .expected (data2[2*FLAG_W-1:FLAG_W]),
    .stored   (RFlagsStored),
    .match    (bfj_match)
  );

  // Opcode decode: next result, a fresh flag vector and the branch-taken bit.
  always_comb begin
    res_d   = '0;
    flags_d = '0;
    zero_d  = 1'b0;
    case (Operation)
      ALU_ADD: begin
        res_d             = sum;
        flags_d[FLAG_OVF] = add_ovf;
      end
      ALU_SUB: begin
        res_d             = diff;
        flags_d[FLAG_OVF] = sub_ovf;
      end
      ALU_MUL: begin
        res_d             = prod[WIDTH-1:0];
        flags_d[FLAG_OVF] = mul_ovf;
        flags_d[FLAG_ERR] = mul_ovf;
      end
      ALU_DIV: begin
        if (div_by_zero) begin
          flags_d[FLAG_ERR] = 1'b1;
        end else if (div_ovf) begin
          res_d             = MIN_NEG;
          flags_d[FLAG_OVF] = 1'b1;
          flags_d[FLAG_ERR] = 1'b1;
        end else begin
          res_d = quot;
        end
      end
      ALU_MOV: res_d = data1;
      ALU_SLW: res_d = data2;
      ALU_AND: res_d = data1 & data2;
      ALU_OR:  res_d = data1 | data2;
      ALU_SHL: res_d = shl_val;
      ALU_SHR: res_d = shr_val;
      ALU_CMP: begin
        flags_d[FLAG_ABOVE] = gt;
        flags_d[FLAG_EQ]    = !gt && !lt;
        flags_d[FLAG_BELOW] = lt;
      end
      ALU_NOT: res_d  = ~data2;
      ALU_JMP: zero_d = 1'b1;
      ALU_BFJ: zero_d = bfj_match;
      ALU_NOP: zero_d = 1'b1;
      default: ;
    endcase
  end

  // Single output register stage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Result    <= '0;
      RFlagsOut <= '0;
      Zero      <= 1'b0;
    end else begin
      Result    <= res_d;
      RFlagsOut <= flags_d;
      Zero      <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed edge cases plus randomized traffic against a model.
module tb_alu_unit;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  Operation;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [6:0]  RFlagsStored;
  logic [31:0] Result;
  logic [6:0]  RFlagsOut;
  logic        Zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  st;
    logic [31:0] r;
    logic [6:0]  f;
    logic        z;
  } vec_t;

  alu_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Operation    (Operation),
    .data1        (data1),
    .data2        (data2),
    .RFlagsStored (RFlagsStored),
    .Result       (Result),
    .RFlagsOut    (RFlagsOut),
    .Zero         (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: signed 64-bit arithmetic straight from the opcode definitions.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [6:0] st, output logic [31:0] r,
                                    output logic [6:0] f, output logic z);
    longint sa, sb, v;
    longint max_pos = 64'sd2147483647;
    longint min_neg = -64'sd2147483648;
    sa = $signed(a);
    sb = $signed(b);
    r = 32'h0;
    f = 7'h0;
    z = 1'b0;
    case (op)
      4'd1: begin v = sa + sb; r = v[31:0]; if (v > max_pos || v < min_neg) f = 7'b1000000; end
      4'd2: begin v = sa - sb; r = v[31:0]; if (v > max_pos || v < min_neg) f = 7'b1000000; end
      4'd3: begin v = sa * sb; r = v[31:0]; if (v > max_pos || v < min_neg) f = 7'b1000001; end
      4'd4: begin
        if (sb == 0) f = 7'b0000001;
        else begin
          v = sa / sb;
          r = v[31:0];
          if (v > max_pos) f = 7'b1000001;
        end
      end
      4'd5: r = a;
      4'd6: r = b;
      4'd7: r = a & b;
      4'd8: r = a | b;
      4'd9: begin
        v = {32'h0, b};
        for (longint i = 0; i < longint'(a) && i < 40; i++) v = v * 2;
        r = v[31:0];
      end
      4'd10: begin
        if (a >= 32) v = (sb < 0) ? -64'sd1 : 64'sd0;
        else v = sb >>> a;
        r = v[31:0];
      end
      4'd11: begin
        if (sa > sb) f = 7'b0100000;
        else if (sa == sb) f = 7'b0010000;
        else f = 7'b0001000;
      end
      4'd12: r = ~b;
      4'd13: z = 1'b1;
      4'd14: begin
        z = 1'b1;
        for (int i = 0; i < 7; i++)
          if (b[i] && (st[i] != b[7+i])) z = 1'b0;
      end
      4'd15: z = 1'b1;
      default: ;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [6:0] st);
    Operation    = op;
    data1        = a;
    data2        = b;
    RFlagsStored = st;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(ALU_UND, 32'h0, 32'h0, 7'h0);
    checks++;
    if ({Result, RFlagsOut, Zero} !== 40'h0) begin
      errors++;
      $display("FAIL reset_state got %h/%b/%b want 0/0/0", Result, RFlagsOut, Zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(ALU_DIV, 32'hFFFF_FFFF, 32'h0, 7'h0);
    Operation = ALU_ADD; data1 = 32'd5; data2 = 32'd7;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({Result, RFlagsOut, Zero} !== 40'h0) begin
      errors++;
      $display("FAIL reset_async got %h/%b/%b want 0/0/0", Result, RFlagsOut, Zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({Result, RFlagsOut, Zero} !== 40'h0) begin
      errors++;
      $display("FAIL reset_hold got %h/%b/%b want 0/0/0", Result, RFlagsOut, Zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (Result !== 32'd12 || RFlagsOut !== 7'h0 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got %h/%b/%b want 0000000c/0000000/0", Result, RFlagsOut, Zero);
    end
  endtask

  task automatic test_add_sub();
    vec_t v[5];
    v[0] = '{ALU_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 7'h7F, 32'hFFFF_FFFE, 7'b1000000, 1'b0};
    v[1] = '{ALU_ADD, 32'h8000_0000, 32'h8000_0000, 7'h00, 32'h0000_0000, 7'b1000000, 1'b0};
    v[2] = '{ALU_SUB, 32'h0000_0000, 32'h7FFF_FFFF, 7'h7F, 32'h8000_0001, 7'b0000000, 1'b0};
    v[3] = '{ALU_SUB, 32'h8000_0000, 32'h0000_0001, 7'h00, 32'h7FFF_FFFF, 7'b1000000, 1'b0};
    v[4] = '{ALU_ADD, 32'h0000_0005, 32'hFFFF_FFFD, 7'h00, 32'h0000_0002, 7'b0000000, 1'b0};
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].st);
      checks++;
      if (Result !== v[i].r || RFlagsOut !== v[i].f || Zero !== v[i].z) begin
        errors++;
        $display("FAIL add_sub[%0d] got %h/%b/%b want %h/%b/%b", i, Result, RFlagsOut, Zero,
                 v[i].r, v[i].f, v[i].z);
      end
    end
  endtask

  task automatic test_mul_div();
    vec_t v[7];
    v[0] = '{ALU_MUL, 32'h0000_0000, 32'h0000_000A, 7'h00, 32'h0000_0000, 7'b0000000, 1'b0};
    v[1] = '{ALU_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 7'h00, 32'h0000_0001, 7'b1000001, 1'b0};
    v[2] = '{ALU_DIV, 32'h7FFF_FFFF, 32'h0000_0000, 7'h00, 32'h0000_0000, 7'b0000001, 1'b0};
    v[3] = '{ALU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 7'h00, 32'hFFFF_FFFD, 7'b0000000, 1'b0};
    v[4] = '{ALU_DIV, 32'h0000_0001, 32'h7FFF_FFFF, 7'h00, 32'h0000_0000, 7'b0000000, 1'b0};
    v[5] = '{ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 7'h00, 32'h8000_0000, 7'b1000001, 1'b0};
    v[6] = '{ALU_MUL, 32'hFFFF_FFFD, 32'h0000_0004, 7'h00, 32'hFFFF_FFF4, 7'b0000000, 1'b0};
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].st);
      checks++;
      if (Result !== v[i].r || RFlagsOut !== v[i].f || Zero !== v[i].z) begin
        errors++;
        $display("FAIL mul_div[%0d] got %h/%b/%b want %h/%b/%b", i, Result, RFlagsOut, Zero,
                 v[i].r, v[i].f, v[i].z);
      end
    end
  endtask

  task automatic test_cmp();
    vec_t v[3];
    v[0] = '{ALU_CMP, 32'hFFFF_FFFB, 32'h0000_0003, 7'h7F, 32'h0, 7'b0001000, 1'b0};
    v[1] = '{ALU_CMP, 32'h0000_0003, 32'hFFFF_FFFB, 7'h00, 32'h0, 7'b0100000, 1'b0};
    v[2] = '{ALU_CMP, 32'h0000_1234, 32'h0000_1234, 7'h00, 32'h0, 7'b0010000, 1'b0};
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].st);
      checks++;
      if (Result !== v[i].r || RFlagsOut !== v[i].f || Zero !== v[i].z) begin
        errors++;
        $display("FAIL cmp[%0d] got %h/%b/%b want %h/%b/%b", i, Result, RFlagsOut, Zero,
                 v[i].r, v[i].f, v[i].z);
      end
    end
  endtask

  task automatic test_shift_move();
    vec_t v[9];
    v[0] = '{ALU_SHL, 32'd4,         32'h0000_0001, 7'h00, 32'h0000_0010, 7'h0, 1'b0};
    v[1] = '{ALU_SHR, 32'd4,         32'h8000_0000, 7'h00, 32'hF800_0000, 7'h0, 1'b0};
    v[2] = '{ALU_SHL, 32'd40,        32'hFFFF_FFFF, 7'h00, 32'h0000_0000, 7'h0, 1'b0};
    v[3] = '{ALU_SHR, 32'h8000_0000, 32'h8000_0000, 7'h00, 32'hFFFF_FFFF, 7'h0, 1'b0};
    v[4] = '{ALU_MOV, 32'hDEAD_BEEF, 32'h0000_0001, 7'h00, 32'hDEAD_BEEF, 7'h0, 1'b0};
    v[5] = '{ALU_SLW, 32'hDEAD_BEEF, 32'h1357_9BDF, 7'h00, 32'h1357_9BDF, 7'h0, 1'b0};
    v[6] = '{ALU_NOT, 32'h1234_5678, 32'h0000_0000, 7'h00, 32'hFFFF_FFFF, 7'h0, 1'b0};
    v[7] = '{ALU_AND, 32'hF0F0_FF00, 32'hFF00_F0F0, 7'h00, 32'hF000_F000, 7'h0, 1'b0};
    v[8] = '{ALU_OR,  32'hF0F0_0000, 32'h0000_0F0F, 7'h00, 32'hF0F0_0F0F, 7'h0, 1'b0};
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].st);
      checks++;
      if (Result !== v[i].r || RFlagsOut !== v[i].f || Zero !== v[i].z) begin
        errors++;
        $display("FAIL shift_move[%0d] got %h/%b/%b want %h/%b/%b", i, Result, RFlagsOut, Zero,
                 v[i].r, v[i].f, v[i].z);
      end
    end
  endtask

  task automatic test_branch();
    vec_t v[8];
    v[0] = '{ALU_JMP, 32'h1111_1111, 32'h2222_2222, 7'h00,       32'h0, 7'h0, 1'b1};
    v[1] = '{ALU_NOP, 32'h1111_1111, 32'h2222_2222, 7'h00,       32'h0, 7'h0, 1'b1};
    v[2] = '{ALU_BFJ, 32'h0000_0000, 32'h0000_0810, 7'b0010000,  32'h0, 7'h0, 1'b1};
    v[3] = '{ALU_BFJ, 32'h0000_0000, 32'h0000_0010, 7'b0010000,  32'h0, 7'h0, 1'b0};
    v[4] = '{ALU_BFJ, 32'hFFFF_FFFF, 32'hFFFF_C000, 7'b1011001,  32'h0, 7'h0, 1'b1};
    v[5] = '{ALU_BFJ, 32'h0000_0000, 32'h0000_20C1, 7'b1000001,  32'h0, 7'h0, 1'b1};
    v[6] = '{ALU_BFJ, 32'h0000_0000, 32'h0000_20C1, 7'b1000000,  32'h0, 7'h0, 1'b0};
    v[7] = '{ALU_UND, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 7'h7F,       32'h0, 7'h0, 1'b0};
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].st);
      checks++;
      if (Result !== v[i].r || RFlagsOut !== v[i].f || Zero !== v[i].z) begin
        errors++;
        $display("FAIL branch[%0d] got %h/%b/%b want %h/%b/%b", i, Result, RFlagsOut, Zero,
                 v[i].r, v[i].f, v[i].z);
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [8];
    edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h2, 32'd31, 32'd32};
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return $urandom_range(0, 40);
      2:       return 32'h0 - $urandom_range(1, 40);
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, er;
    logic [6:0]  st, ef;
    logic        ez;
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick_operand();
      b  = pick_operand();
      st = 7'($urandom());
      if (op == ALU_BFJ && $urandom_range(0, 1) == 1)
        b = {b[31:14], st & b[6:0], b[6:0]};
      ref_model(op, a, b, st, er, ef, ez);
      drive(op, a, b, st);
      checks++;
      if (Result !== er || RFlagsOut !== ef || Zero !== ez) begin
        errors++;
        $display("FAIL random[%0d] op=%h a=%h b=%h st=%b got %h/%b/%b want %h/%b/%b", i, op, a, b,
                 st, Result, RFlagsOut, Zero, er, ef, ez);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [8];
    logic [31:0] as  [8];
    logic [31:0] bs  [8];
    logic [31:0] er;
    logic [6:0]  ef;
    logic        ez;
    ops = '{ALU_DIV, ALU_MOV, ALU_CMP, ALU_JMP, ALU_MUL, ALU_UND, ALU_SUB, ALU_NOP};
    as  = '{32'h5, 32'h9, 32'h3, 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0};
    bs  = '{32'h0, 32'h0, 32'h3, 32'h0, 32'h2, 32'h1, 32'h1, 32'h0};
    foreach (ops[i]) begin
      ref_model(ops[i], as[i], bs[i], 7'h7F, er, ef, ez);
      drive(ops[i], as[i], bs[i], 7'h7F);
      checks++;
      if (Result !== er || RFlagsOut !== ef || Zero !== ez) begin
        errors++;
        $display("FAIL back_to_back[%0d] got %h/%b/%b want %h/%b/%b", i, Result, RFlagsOut, Zero,
                 er, ef, ez);
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    Operation    = ALU_UND;
    data1        = 32'h0;
    data2        = 32'h0;
    RFlagsStored = 7'h0;
    test_reset();
    test_add_sub();
    test_mul_div();
    test_cmp();
    test_shift_move();
    test_branch();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
